// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD text feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_GAP,
        ST_FINISH
    } lcd_state_t;

    localparam logic [7:0] LCD_CMD_SET_DDRAM_L1 = 8'h80;
    localparam logic [7:0] LCD_CMD_SET_DDRAM_L2 = 8'hC0;
    localparam logic [7:0] LCD_CMD_CLEAR        = 8'h01;
    localparam logic [7:0] LCD_CHAR_SPACE       = 8'h20;

    // lcd_bus layout: {rs, rw, data[7:0]}
    localparam int RS_BIT = 9;
    localparam int RW_BIT = 8;

    localparam int LCD_LINE_LEN  = 16;
    localparam int LCD_NUM_CHARS = 2 * LCD_LINE_LEN;
    // Base transfer list: set-address + 16 chars, per line.
    localparam int LCD_STD_STEPS = 2 * (LCD_LINE_LEN + 1);
    // Index of the line-2 set-address command within the base list.
    localparam int STEP_L2       = LCD_LINE_LEN + 1;

    function automatic logic [9:0] lcd_word(input logic rs, input logic [7:0] data);
        logic [9:0] w;
        w         = '0;
        w[RS_BIT] = rs;
        w[RW_BIT] = 1'b0;
        w[7:0]    = data;
        return w;
    endfunction

endpackage

// File: rtl/lcd_frame_buf.sv
// 32x8 character frame buffer: one synchronous write port, one combinational read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; writes are always accepted.
//
// Ports: clk, rst (sync, active-high: every entry back to space),
//        wr_en/wr_addr/wr_char write port, rd_addr -> rd_char read port.
module lcd_frame_buf
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_char,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char
);

    logic [7:0] mem [0:LCD_NUM_CHARS-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LCD_NUM_CHARS; i++) begin
                mem[i] <= LCD_CHAR_SPACE;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_char;
        end
    end

    assign rd_char = mem[rd_addr];

endmodule

// File: rtl/lcd_text_feeder.sv
// Streams the 2x16 frame buffer to the LCD controller as set-address + 16 chars per line.
// Latency: first lcd_enable 1 clock after refresh_req in IDLE (busy low); GAP_CYCLES hold-off after each ack.
// Backpressure: waits in ISSUE while lcd_busy is high; extra refresh requests merge into one pending flag.
//
// Ports: clk, rst (sync, active-high); wr_en/wr_addr/wr_char host buffer writes;
//        refresh_req start pulse; lcd_busy/lcd_enable/lcd_bus controller handshake;
//        active (refresh running), done (end pulse), ack_err (sticky missing-busy flag).
// Build option: define LCD_CLEAR_EN to prepend a clear-display command with its own
//               CLEAR_GAP_CYCLES hold-off; otherwise CLEAR_GAP_CYCLES is ignored.
module lcd_text_feeder
    import lcd_pkg::*;
#(
    parameter int GAP_CYCLES       = 2400,
    parameter int ACK_TIMEOUT      = 4,
    parameter int CLEAR_GAP_CYCLES = 90000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_char,
    input  logic       refresh_req,
    input  logic       lcd_busy,
    output logic       lcd_enable,
    output logic [9:0] lcd_bus,
    output logic       active,
    output logic       done,
    output logic       ack_err
);

`ifdef LCD_CLEAR_EN
    localparam int PRE_STEPS = 1;
    localparam int MAX_GAP   = (CLEAR_GAP_CYCLES > GAP_CYCLES) ? CLEAR_GAP_CYCLES : GAP_CYCLES;
`else
    localparam int PRE_STEPS = 0;
    localparam int MAX_GAP   = GAP_CYCLES;
`endif
    localparam int LAST_STEP = LCD_STD_STEPS - 1 + PRE_STEPS;
    localparam int CW        = $clog2(MAX_GAP) + 1;
    localparam int AW        = $clog2(ACK_TIMEOUT + 1);

    // The counter is loaded on the ack edge and the FSM leaves GAP on the edge
    // it reads zero, so loading N-1 keeps the FSM in GAP for exactly N cycles.
    localparam logic [CW-1:0] GAP_LOAD = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
`ifdef LCD_CLEAR_EN
    localparam logic [CW-1:0] CLEAR_LOAD = CW'((CLEAR_GAP_CYCLES > 0) ? CLEAR_GAP_CYCLES - 1 : 0);
`endif

    lcd_state_t       state;
    logic [5:0]       step;
    logic [5:0]       std_step;
    logic [CW-1:0]    gap_cnt;
    logic [CW-1:0]    gap_load;
    logic [AW-1:0]    ack_cnt;
    logic             pending;
    logic [4:0]       rd_addr;
    logic [7:0]       rd_char;
    logic [9:0]       cur_word;

    lcd_frame_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_char (wr_char),
        .rd_addr (rd_addr),
        .rd_char (rd_char)
    );

    // Position in the base 34-entry list; the optional clear command sits ahead of it.
    assign std_step = step - 6'(PRE_STEPS);

    // Word for the current step. The buffer is read combinationally, so the
    // character latched into lcd_bus is whatever is stored on the ISSUE edge.
    always_comb begin
        rd_addr  = '0;
        cur_word = lcd_word(1'b0, LCD_CMD_SET_DDRAM_L1);
        if (std_step == 6'd0) begin
            cur_word = lcd_word(1'b0, LCD_CMD_SET_DDRAM_L1);
        end else if (std_step == 6'(STEP_L2)) begin
            cur_word = lcd_word(1'b0, LCD_CMD_SET_DDRAM_L2);
        end else if (std_step < 6'(STEP_L2)) begin
            rd_addr  = 5'(std_step - 6'd1);
            cur_word = lcd_word(1'b1, rd_char);
        end else begin
            rd_addr  = 5'(std_step - 6'd2);
            cur_word = lcd_word(1'b1, rd_char);
        end
`ifdef LCD_CLEAR_EN
        if (step == 6'd0) begin
            cur_word = lcd_word(1'b0, LCD_CMD_CLEAR);
        end
`endif
    end

    always_comb begin
        gap_load = GAP_LOAD;
`ifdef LCD_CLEAR_EN
        if (step == 6'd0) begin
            gap_load = CLEAR_LOAD;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            step       <= '0;
            gap_cnt    <= '0;
            ack_cnt    <= '0;
            pending    <= 1'b0;
            lcd_enable <= 1'b0;
            lcd_bus    <= '0;
            active     <= 1'b0;
            done       <= 1'b0;
            ack_err    <= 1'b0;
        end else begin
            lcd_enable <= 1'b0;
            done       <= 1'b0;

            // Any request outside IDLE is remembered; FINISH consumes it below.
            if (refresh_req && state != ST_IDLE) begin
                pending <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (refresh_req) begin
                        state   <= ST_ISSUE;
                        step    <= '0;
                        active  <= 1'b1;
                        ack_err <= 1'b0;
                    end
                end

                ST_ISSUE: begin
                    if (!lcd_busy) begin
                        lcd_enable <= 1'b1;
                        lcd_bus    <= cur_word;
                        ack_cnt    <= '0;
                        state      <= ST_WAIT_ACK;
                    end
                end

                ST_WAIT_ACK: begin
                    if (lcd_busy) begin
                        gap_cnt <= gap_load;
                        state   <= ST_GAP;
                    end else if (ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
                        // No acceptance seen: flag it but keep the frame going.
                        ack_err <= 1'b1;
                        gap_cnt <= gap_load;
                        state   <= ST_GAP;
                    end else begin
                        ack_cnt <= ack_cnt + AW'(1);
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        if (step == 6'(LAST_STEP)) begin
                            state  <= ST_FINISH;
                            done   <= 1'b1;
                            active <= 1'b0;
                        end else begin
                            step  <= step + 6'd1;
                            state <= ST_ISSUE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - CW'(1);
                    end
                end

                ST_FINISH: begin
                    if (pending || refresh_req) begin
                        pending <= 1'b0;
                        step    <= '0;
                        active  <= 1'b1;
                        ack_err <= 1'b0;
                        state   <= ST_ISSUE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_text_feeder.sv
// Bench for lcd_text_feeder: short gaps, scripted busy responses, reference transfer model.
module tb_lcd_text_feeder;

    localparam int GAP    = 8;
    localparam int ACK_TO = 4;
    localparam int CLR_GAP = 20;
`ifdef LCD_CLEAR_EN
    localparam int PRE = 1;
`else
    localparam int PRE = 0;
`endif
    localparam int NT = 34 + PRE;
    localparam int RUN_BUDGET = NT * (ACK_TO + GAP + 4) + CLR_GAP + 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [7:0] wr_char = '0;
    logic       refresh_req = 1'b0;
    logic       lcd_busy;
    logic       lcd_enable;
    logic [9:0] lcd_bus;
    logic       active;
    logic       done;
    logic       ack_err;

    logic busy_force = 1'b0;
    logic busy_ack   = 1'b0;
    logic auto_ack   = 1'b1;
    assign lcd_busy = busy_force | busy_ack;

    lcd_text_feeder #(
        .GAP_CYCLES       (GAP),
        .ACK_TIMEOUT      (ACK_TO),
        .CLEAR_GAP_CYCLES (CLR_GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_char     (wr_char),
        .refresh_req (refresh_req),
        .lcd_busy    (lcd_busy),
        .lcd_enable  (lcd_enable),
        .lcd_bus     (lcd_bus),
        .active      (active),
        .done        (done),
        .ack_err     (ack_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observations, stamped with the number of rising edges seen so far.
    int         en_cyc[$];
    logic [9:0] en_bus[$];
    int         ack_d[$];
    int         done_cyc[$];
    int         err_rise[$];
    int         act_fall[$];
    logic prev_en = 1'b0, prev_err = 1'b0, prev_act = 1'b0;
    int req_edge;

    logic [7:0] mbuf [0:31];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    always @(negedge clk) begin
        if (lcd_enable) begin
            en_cyc.push_back(cyc);
            en_bus.push_back(lcd_bus);
            checks++;
            if (prev_en) begin
                errors++;
                $display("FAIL enable_back_to_back: got 2 consecutive cycles expected 1 at cycle %0d", cyc);
            end
        end
        if (done) done_cyc.push_back(cyc);
        if (ack_err && !prev_err) err_rise.push_back(cyc);
        if (!active && prev_act) act_fall.push_back(cyc);
        prev_en  = lcd_enable;
        prev_err = ack_err;
        prev_act = active;
    end

    // Controller stand-in: busy for one cycle, 0-2 cycles after it sees enable.
    always @(negedge clk) begin
        if (lcd_enable) begin
            if (auto_ack) begin
                int d;
                d = $urandom_range(0, 2);
                ack_d.push_back(d);
                repeat (d) @(negedge clk);
                busy_ack = 1'b1;
                @(negedge clk);
                busy_ack = 1'b0;
            end else begin
                ack_d.push_back(-1);
            end
        end
    end

    // Reference: the k-th transfer word of a refresh, from the model buffer.
    function automatic logic [9:0] exp_word(input int k);
        int s;
        if (PRE == 1 && k == 0) return 10'h001;
        s = k - PRE;
        if (s == 0)  return 10'h080;
        if (s == 17) return 10'h0C0;
        if (s < 17)  return {2'b10, mbuf[s - 1]};
        return {2'b10, mbuf[s - 2]};
    endfunction

    // Clocks from an enable to the end of its hold-off (the edge FINISH is entered).
    // Ack is sampled d+1 edges after the enable, or ACK_TO edges on timeout, then GAP lasts g.
    function automatic int hold_after(input int k, input int d);
        int a, g;
        a = (d < 0) ? ACK_TO : d + 1;
        g = (PRE == 1 && k == 0) ? CLR_GAP : GAP;
        return a + g;
    endfunction

    task automatic write_char(input logic [4:0] a, input logic [7:0] c);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_char = c;
        @(negedge clk);
        wr_en   = 1'b0;
        mbuf[a] = c;
    endtask

    task automatic pulse_req();
        refresh_req = 1'b1;
        req_edge    = cyc + 1;
        @(negedge clk);
        refresh_req = 1'b0;
    endtask

    task automatic start_run();
        en_cyc.delete(); en_bus.delete(); ack_d.delete();
        done_cyc.delete(); err_rise.delete(); act_fall.delete();
        pulse_req();
    endtask

    task automatic wait_dones(input string tag, input int n);
        int t = 0;
        while (done_cyc.size() < n && t < n * RUN_BUDGET) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " done_count"}, done_cyc.size(), n);
        repeat (40) @(negedge clk);
    endtask

    task automatic wait_enables(input string tag, input int n);
        int t = 0;
        while (en_cyc.size() < n && t < RUN_BUDGET) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " enable_reached"}, en_cyc.size() >= n, 1);
    endtask

    task automatic verify_runs(input string tag, input int nruns);
        chk({tag, " enable_count"}, en_bus.size(), nruns * NT);
        chk({tag, " done_pulses"}, done_cyc.size(), nruns);
        if (en_bus.size() == nruns * NT && ack_d.size() == nruns * NT && done_cyc.size() == nruns) begin
            for (int i = 0; i < nruns * NT; i++) begin
                int k = i % NT;
                chk($sformatf("%s bus[%0d]", tag, i), en_bus[i], exp_word(k));
                if (k != NT - 1)
                    chk($sformatf("%s spacing[%0d]", tag, i), en_cyc[i + 1] - en_cyc[i],
                        hold_after(k, ack_d[i]) + 1);
                else
                    chk($sformatf("%s done_time[%0d]", tag, i / NT), done_cyc[i / NT],
                        en_cyc[i] + hold_after(k, ack_d[i]));
            end
            chk({tag, " active_falls_with_done"}, (act_fall.size() > 0) ? act_fall[0] : -1, done_cyc[0]);
        end
    endtask

    typedef struct {
        string      name;
        logic [4:0] addr;
        logic [7:0] ch;
        int         k;
        logic [9:0] exp;
    } vec_t;

    initial begin
        vec_t tv[6];
        int   rel;
        int   t;

        tv[0] = '{"char_a",   5'd0,  8'h41, PRE + 1,  10'h241};
        tv[1] = '{"char_b",   5'd16, 8'h42, PRE + 18, 10'h242};
        tv[2] = '{"l1_end",   5'd15, 8'h20, PRE + 16, 10'h220};
        tv[3] = '{"l2_end",   5'd31, 8'h20, PRE + 33, 10'h220};
        tv[4] = '{"set_l1",   5'd1,  8'h20, PRE + 0,  10'h080};
        tv[5] = '{"set_l2",   5'd17, 8'h20, PRE + 17, 10'h0C0};

        for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst lcd_enable", lcd_enable, 0);
        chk("rst lcd_bus", lcd_bus, 0);
        chk("rst active", active, 0);
        chk("rst done", done, 0);
        chk("rst ack_err", ack_err, 0);
        rst = 1'b0;
        @(negedge clk);

        // Table: known characters at line starts, spaces elsewhere
        foreach (tv[i]) write_char(tv[i].addr, tv[i].ch);
        start_run();
        wait_dones("t1", 1);
        chk("t1 first_enable_latency", (en_cyc.size() > 0) ? en_cyc[0] - req_edge : -1, 1);
        foreach (tv[i])
            chk({"t1 ", tv[i].name}, (en_bus.size() > tv[i].k) ? int'(en_bus[tv[i].k]) : -1, tv[i].exp);
        verify_runs("t1", 1);
        chk("t1 ack_err", ack_err, 0);
        chk("t1 active_idle", active, 0);

        // Random frame contents
        for (int i = 0; i < 32; i++) write_char(5'(i), 8'($urandom_range(33, 126)));
        repeat ($urandom_range(0, 5)) @(negedge clk);
        start_run();
        wait_dones("rand", 1);
        verify_runs("rand", 1);

        // Busy held high at start: nothing may be issued until it drops
        busy_force = 1'b1;
        start_run();
        repeat (20) @(negedge clk);
        chk("t2 no_enable_while_busy", en_cyc.size(), 0);
        busy_force = 1'b0;
        rel = cyc;
        wait_dones("t2", 1);
        chk("t2 enable_after_release", (en_cyc.size() > 0) ? en_cyc[0] - rel : -1, 1);
        verify_runs("t2", 1);

        // Controller never acknowledges
        auto_ack = 1'b0;
        start_run();
        wait_dones("t3", 1);
        chk("t3 ack_err_time",
            (err_rise.size() > 0 && en_cyc.size() > 0) ? err_rise[0] - en_cyc[0] : -1, ACK_TO);
        verify_runs("t3", 1);
        chk("t3 ack_err_sticky", ack_err, 1);
        auto_ack = 1'b1;
        start_run();
        chk("t3 ack_err_cleared", ack_err, 0);
        wait_dones("t3b", 1);
        verify_runs("t3b", 1);

        // Two requests during a refresh merge into one extra refresh
        start_run();
        wait_enables("t4", 5);
        pulse_req();
        wait_enables("t4", 20);
        pulse_req();
        wait_dones("t4", 2);
        verify_runs("t4", 2);
        chk("t4 restart_time", (en_cyc.size() > NT && done_cyc.size() > 0) ? en_cyc[NT] - done_cyc[0] : -1, 2);

        // Request landing in the FINISH cycle
        start_run();
        t = 0;
        while (!done && t < RUN_BUDGET) begin
            @(negedge clk);
            t++;
        end
        chk("t4b done_seen", done, 1);
        pulse_req();
        wait_dones("t4b", 2);
        verify_runs("t4b", 2);
        chk("t4b restart_time", (en_cyc.size() > NT && done_cyc.size() > 0) ? en_cyc[NT] - done_cyc[0] : -1, 2);

        // Reset during step 10 (buffer holds random characters from earlier)
        start_run();
        wait_enables("t5", PRE + 11);
        rst = 1'b1;
        @(negedge clk);
        chk("t5 enable_after_rst", lcd_enable, 0);
        chk("t5 active_after_rst", active, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
        repeat (40) @(negedge clk);
        chk("t5 no_more_enables", en_cyc.size(), PRE + 11);
        chk("t5 no_done", done_cyc.size(), 0);
        start_run();
        wait_dones("t5b", 1);
        verify_runs("t5b", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
